// File: rtl/stack_sequencer.sv
// stack_sequencer -- core sequencer for a "stacker" LED-matrix game.
//
// A single lit block bounces across an 8-column row on move_tick. Pressing
// drop locks it on top of the stack. Each drop must land exactly on the
// block below it. Locking NUM_ROWS blocks wins the game; a miss loses it.
// While in WIN or LOSE, the display flashes on blink_tick for
// FLASH_TOGGLES toggles, and then the sequencer returns to IDLE.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   move_tick   one-cycle step pulse for the moving block
//   blink_tick  one-cycle pulse that paces end-state flashing
//   drop        one-cycle, debounced lock request
//   move_cols   one-hot column of the moving block (registered)
//   base_cols   column pattern of the locked stack (registered)
//   level       rows locked, 0..NUM_ROWS (registered)
//   move_row_n  active-low select of the moving row (registered)
//   stack_rows  active-high mask of the locked rows (registered)
//   game_state  IDLE=00, PLAY=01, WIN=10, LOSE=11
//   flash       blink phase in WIN/LOSE, 0 otherwise
module stack_sequencer #(
    parameter int NUM_ROWS      = 8,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic       blink_tick,
    input  logic       drop,
    output logic [7:0] move_cols,
    output logic [7:0] base_cols,
    output logic [3:0] level,
    output logic [7:0] move_row_n,
    output logic [7:0] stack_rows,
    output logic [1:0] game_state,
    output logic       flash
);
    localparam int CW = $clog2(FLASH_TOGGLES + 1);
    localparam logic [3:0]    LVL_MAX = 4'(NUM_ROWS);
    localparam logic [CW-1:0] CNT_MAX = CW'(FLASH_TOGGLES);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, WIN = 2'b10, LOSE = 2'b11} state_t;

    state_t        state, state_nxt;
    logic [2:0]    pos, pos_nxt;
    logic          dir, dir_nxt;        // 0 = moving right (toward col 7), 1 = left
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    level_nxt;
    logic [7:0]    base_nxt;
    logic          flash_nxt;
    logic          hit;
    logic          flash_done;

    // The comparison uses the registered move_cols, which is the pre-step
    // position, even when move_tick arrives in the same cycle.
    assign hit        = (move_cols == base_cols);
    assign flash_done = (cnt == CNT_MAX);
    assign game_state = state;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (drop) state_nxt = PLAY;
            PLAY: if (drop) begin
                if (!hit)                          state_nxt = LOSE;
                else if (level + 4'd1 == LVL_MAX)  state_nxt = WIN;
            end
            default: if (drop || flash_done) state_nxt = IDLE;  // WIN, LOSE
        endcase
    end

    // Datapath next values
    always_comb begin
        pos_nxt   = pos;
        dir_nxt   = dir;
        level_nxt = level;
        base_nxt  = base_cols;
        flash_nxt = flash;
        cnt_nxt   = cnt;

        // The block bounces only while the game is live. It reverses at the
        // edges without dwelling, which gives a 14-tick period.
        if (move_tick && (state == IDLE || state == PLAY)) begin
            if (!dir) begin
                if (pos == 3'd7) begin dir_nxt = 1'b1; pos_nxt = 3'd6; end
                else             pos_nxt = pos + 3'd1;
            end else begin
                if (pos == 3'd0) begin dir_nxt = 1'b0; pos_nxt = 3'd1; end
                else             pos_nxt = pos - 3'd1;
            end
        end

        case (state)
            IDLE: if (drop) begin
                base_nxt  = move_cols;
                level_nxt = 4'd1;
            end
            PLAY: if (drop && hit) level_nxt = level + 4'd1;
            default: begin
                if (drop || flash_done) begin
                    level_nxt = 4'd0;
                    base_nxt  = 8'h00;
                    flash_nxt = 1'b0;
                    cnt_nxt   = '0;
                end else if (blink_tick) begin
                    flash_nxt = ~flash;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
        endcase
    end

    // Datapath and output registers. The row masks are derived from the
    // next level, so they update on the same edge as level does.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos        <= 3'd0;
            dir        <= 1'b0;
            cnt        <= '0;
            flash      <= 1'b0;
            level      <= 4'd0;
            base_cols  <= 8'h00;
            move_cols  <= 8'h80;
            move_row_n <= 8'h7F;
            stack_rows <= 8'h00;
        end else begin
            pos        <= pos_nxt;
            dir        <= dir_nxt;
            cnt        <= cnt_nxt;
            flash      <= flash_nxt;
            level      <= level_nxt;
            base_cols  <= base_nxt;
            move_cols  <= 8'h80 >> pos_nxt;
            move_row_n <= (level_nxt >= LVL_MAX) ? 8'hFF : ~(8'h80 >> level_nxt);
            stack_rows <= (level_nxt >= LVL_MAX) ? 8'hFF : ~(8'hFF >> level_nxt);
        end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// Directed testbench for stack_sequencer. It drives hand-chosen pulses and
// checks the registered outputs 1 ns after each rising edge.
module tb_stack_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_tick = 1'b0, blink_tick = 1'b0, drop = 1'b0;
    logic [7:0] move_cols, base_cols, move_row_n, stack_rows;
    logic [3:0] level;
    logic [1:0] game_state;
    logic       flash;

    int n_chk = 0;
    int n_err = 0;

    stack_sequencer #(.NUM_ROWS(8), .FLASH_TOGGLES(6)) dut (
        .clk(clk), .reset(reset), .move_tick(move_tick), .blink_tick(blink_tick),
        .drop(drop), .move_cols(move_cols), .base_cols(base_cols), .level(level),
        .move_row_n(move_row_n), .stack_rows(stack_rows), .game_state(game_state),
        .flash(flash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic d, input logic m, input logic b, input logic r);
        drop = d; move_tick = m; blink_tick = b; reset = r;
        @(posedge clk);
        #1;
        drop = 1'b0; move_tick = 1'b0; blink_tick = 1'b0; reset = 1'b0;
    endtask

    // Step the block until it shows tgt. One bounce period of ticks is
    // always enough.
    task automatic seek(input logic [7:0] tgt);
        for (int i = 0; i < 14 && move_cols != tgt; i++) cyc(0, 1, 0, 0);
        chk("seek", move_cols, tgt);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, game_state, 2'b00);
        chk({tag, "_move"},  move_cols,  8'h80);
        chk({tag, "_base"},  base_cols,  8'h00);
        chk({tag, "_level"}, level,      4'd0);
        chk({tag, "_rown"},  move_row_n, 8'h7F);
        chk({tag, "_stack"}, stack_rows, 8'h00);
        chk({tag, "_flash"}, flash,      1'b0);
    endtask

    logic [7:0] bounce [14] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        cyc(0, 0, 0, 1);
        chk_reset("rst");

        // Full bounce period
        for (int i = 0; i < 14; i++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("bounce%0d", i), move_cols, bounce[i]);
        end

        // First lock from IDLE at column 0x20
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pre_drop", move_cols, 8'h20);
        cyc(1, 0, 0, 0);
        chk("l1_base",  base_cols,  8'h20);
        chk("l1_level", level,      4'd1);
        chk("l1_state", game_state, 2'b01);
        chk("l1_rown",  move_row_n, 8'hBF);
        chk("l1_stack", stack_rows, 8'h80);

        // Drop and step in the same cycle: lock uses 0x20, block still moves.
        cyc(1, 1, 0, 0);
        chk("same_level", level,      4'd2);
        chk("same_move",  move_cols,  8'h10);
        chk("same_rown",  move_row_n, 8'hDF);
        chk("same_stack", stack_rows, 8'hC0);
        chk("same_state", game_state, 2'b01);

        // Remaining six matching drops reach WIN
        for (int i = 3; i <= 8; i++) begin
            seek(8'h20);
            cyc(1, 0, 0, 0);
            chk($sformatf("lvl%0d", i), level, i[3:0]);
        end
        chk("win_state", game_state, 2'b10);
        chk("win_stack", stack_rows, 8'hFF);
        chk("win_rown",  move_row_n, 8'hFF);
        chk("win_base",  base_cols,  8'h20);

        // Block is frozen in WIN
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("win_frozen", move_cols, 8'h20);

        // Flash sequence: 1,0,1,0,1,0, then IDLE on the following cycle
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("flash%0d", i), flash, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("flash_st%0d", i), game_state, 2'b10);
        end
        cyc(0, 0, 0, 0);
        chk("win_idle_state", game_state, 2'b00);
        chk("win_idle_level", level,      4'd0);
        chk("win_idle_base",  base_cols,  8'h00);
        chk("win_idle_rown",  move_row_n, 8'h7F);
        chk("win_idle_stack", stack_rows, 8'h00);
        chk("win_idle_pos",   move_cols,  8'h20);

        // Miss at level 3 -> LOSE, level and base hold
        cyc(1, 0, 0, 0);
        chk("g2_l1", level, 4'd1);
        seek(8'h20); cyc(1, 0, 0, 0);
        seek(8'h20); cyc(1, 0, 0, 0);
        chk("g2_l3", level, 4'd3);
        seek(8'h04);
        cyc(1, 0, 0, 0);
        chk("lose_state", game_state, 2'b11);
        chk("lose_level", level,      4'd3);
        chk("lose_base",  base_cols,  8'h20);
        cyc(0, 1, 0, 0);
        chk("lose_frozen", move_cols, 8'h04);
        cyc(0, 0, 1, 0);
        chk("lose_flash", flash, 1'b1);
        // Drop ends LOSE early
        cyc(1, 0, 0, 0);
        chk("lose_drop_state", game_state, 2'b00);
        chk("lose_drop_level", level,      4'd0);
        chk("lose_drop_flash", flash,      1'b0);

        // Reset wins over drop and move_tick mid-game
        cyc(1, 0, 0, 0);
        chk("g3_state", game_state, 2'b01);
        cyc(1, 1, 0, 1);
        chk_reset("rst2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
